// File: rtl/icache_if.sv
// Fetch-stage request/response bundle for the direct-mapped instruction cache.
// The fetch stage drives the master side and the cache is the slave.
interface icache_if;
    logic        read_i;
    logic [31:0] read_addr_i;
    logic        write_i;
    logic [31:0] write_addr_i;
    logic [31:0] write_inst_i;
    logic        flush_i;
    logic        read_hit_o;
    logic [31:0] read_inst_o;
    logic        busy_o;

    modport master (
        output read_i, read_addr_i, write_i, write_addr_i, write_inst_i, flush_i,
        input  read_hit_o, read_inst_o, busy_o
    );

    modport slave (
        input  read_i, read_addr_i, write_i, write_addr_i, write_inst_i, flush_i,
        output read_hit_o, read_inst_o, busy_o
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with fill forwarding and a
// one-line-per-cycle flush sweep. Define ICACHE_STATS_EN to add hit/miss counters.
module icache #(
    parameter int INDEX_W = 7
) (
    input  logic        clk,
    input  logic        rst,
    icache_if.slave     bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 30 - INDEX_W;
    localparam logic [INDEX_W-1:0] LAST_IDX = {INDEX_W{1'b1}};
    localparam logic [INDEX_W-1:0] ONE_IDX  = {{(INDEX_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [INDEX_W-1:0]  cnt_q, cnt_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [31:0]         data_q [LINES];
    logic                read_hit_q, read_hit_d;
    logic [31:0]         read_inst_q, read_inst_d;

    logic                flush_start_s;
    logic                clr_en_s;
    logic                fill_en_s;
    logic                lookup_s;
    logic [INDEX_W-1:0]  r_idx_s, w_idx_s;
    logic [TAG_W-1:0]    r_tag_s, w_tag_s;
    logic                unused_addr_bits_s;

    assign r_idx_s = bus.read_addr_i[INDEX_W+1:2];
    assign r_tag_s = bus.read_addr_i[31:INDEX_W+2];
    assign w_idx_s = bus.write_addr_i[INDEX_W+1:2];
    assign w_tag_s = bus.write_addr_i[31:INDEX_W+2];
    assign unused_addr_bits_s = ^{bus.read_addr_i[1:0], bus.write_addr_i[1:0]};

    // FSM state and sweep counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; flush in IDLE pre-empts both the fill and the lookup
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        flush_start_s = 1'b0;
        clr_en_s      = 1'b0;
        fill_en_s     = 1'b0;
        lookup_s      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.flush_i) begin
                    state_d       = S_FLUSH;
                    cnt_d         = '0;
                    flush_start_s = 1'b1;
                end else begin
                    fill_en_s = bus.write_i;
                    lookup_s  = bus.read_i;
                end
            end
            S_FLUSH: begin
                clr_en_s = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE_IDX;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Valid-bit update: sweep clears, fills set
    always_comb begin
        valid_d = valid_q;
        if (clr_en_s) begin
            valid_d[cnt_q] = 1'b0;
        end else if (fill_en_s) begin
            valid_d[w_idx_s] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Valid bits are the only per-line state that needs a reset value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data storage, written on fill only
    always_ff @(posedge clk) begin
        if (fill_en_s) begin
            tag_q[w_idx_s]  <= w_tag_s;
            data_q[w_idx_s] <= bus.write_inst_i;
        end
    end

    // Lookup; a same-cycle fill to the same line wins over the stored contents
    always_comb begin
        read_hit_d  = 1'b0;
        read_inst_d = read_inst_q;
        if (lookup_s) begin
            if (fill_en_s && (w_idx_s == r_idx_s)) begin
                read_hit_d  = (w_tag_s == r_tag_s);
                read_inst_d = bus.write_inst_i;
            end else begin
                read_hit_d  = valid_q[r_idx_s] && (tag_q[r_idx_s] == r_tag_s);
                read_inst_d = data_q[r_idx_s];
            end
        end else begin
            read_hit_d  = 1'b0;
            read_inst_d = read_inst_q;
        end
    end

    // Registered lookup result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_hit_q  <= 1'b0;
            read_inst_q <= 32'h0000_0000;
        end else begin
            read_hit_q  <= read_hit_d;
            read_inst_q <= read_inst_d;
        end
    end

    assign bus.read_hit_o  = read_hit_q;
    assign bus.read_inst_o = read_inst_q;
    assign bus.busy_o      = (state_q == S_FLUSH);

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Counters restart on every flush and count only accepted IDLE lookups
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (flush_start_s) begin
            hit_cnt_d  = 32'h0000_0000;
            miss_cnt_d = 32'h0000_0000;
        end else if (lookup_s) begin
            if (read_hit_d) begin
                hit_cnt_d = hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end else begin
            hit_cnt_d  = hit_cnt_q;
            miss_cnt_d = miss_cnt_q;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= 32'h0000_0000;
            miss_cnt_q <= 32'h0000_0000;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
